// File: rtl/bexkat2_bus_arbiter_pkg.sv
// Shared types for the bexkat2 memory-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// arb_state_t : arbiter grant state (idle / fetch owns bus / data owns bus)
// owner_t     : which requester held the bus last, used for round-robin ties
package bexkat1Def;

   typedef enum bit [1:0] {
      ARB_IDLE = 2'd0,
      ARB_INS  = 2'd1,
      ARB_DAT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_INS = 1'b0,
      OWN_DAT = 1'b1
   } owner_t;

   // Instruction fetches are always full-word reads.
   localparam logic INS_WE = 1'b0;

endpackage

// File: rtl/bexkat2_bus_watchdog.sv
// Stall watchdog: counts strobed cycles without ack/err and pulses expire_o once.
// Latency: expire_o rises the cycle after the TIMEOUT-th unanswered strobe cycle.
// Backpressure: none; purely observes the bus, TIMEOUT=0 disables it.
//
// Ports:
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : force counter clear (no owner driving a cycle)
//   stb_i        : strobe currently presented to memory
//   done_i       : memory answered (ack or err) this cycle
//   expire_o     : registered one-cycle error pulse
module bexkat2_bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic stb_i,
   input  logic done_i,
   output logic expire_o
);

   // TIMEOUT=0 still needs a legal one-bit counter; it simply never advances.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam bit            WD_EN    = (TIMEOUT > 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count    <= '0;
         expire_o <= 1'b0;
      end else begin
         expire_o <= 1'b0;
         if (clr_i || !stb_i || done_i) begin
            count <= '0;
         end else if (WD_EN && (count == CNT_LAST)) begin
            count    <= '0;
            expire_o <= 1'b1;
         end else if (count != CNT_MAX) begin
            // Saturate rather than wrap so a stuck counter can never alias to zero.
            count <= count + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/bexkat2_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic memory bus between fetch and data ports.
// Latency: grant registered, bus_cyc_o follows a request from idle by one cycle; data path combinational.
// Backpressure: non-owner waits (no ack) until owner drops cyc plus one idle cycle; watchdog errors stalls.
//
// Ports:
//   clk_i, rst_i         : clock, async active-high reset
//   ins_*                : fetch master (read-only): cyc/stb/adr in, dat/ack/err out
//   dat_*                : data master: cyc/stb/we/sel/adr/dat in, dat/ack/err out
//   bus_*                : memory slave side: cyc/stb/we/sel/adr/dat out, dat/ack/err in
//   timeout_o            : one-cycle pulse when the watchdog forces an error
module bexkat2_bus_arbiter
   import bexkat1Def::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            ins_cyc_i,
   input  logic            ins_stb_i,
   input  logic [AW-1:0]   ins_adr_i,
   output logic [DW-1:0]   ins_dat_o,
   output logic            ins_ack_o,
   output logic            ins_err_o,
   input  logic            dat_cyc_i,
   input  logic            dat_stb_i,
   input  logic            dat_we_i,
   input  logic [DW/8-1:0] dat_sel_i,
   input  logic [AW-1:0]   dat_adr_i,
   input  logic [DW-1:0]   dat_dat_i,
   output logic [DW-1:0]   dat_dat_o,
   output logic            dat_ack_o,
   output logic            dat_err_o,
   output logic            bus_cyc_o,
   output logic            bus_stb_o,
   output logic            bus_we_o,
   output logic [DW/8-1:0] bus_sel_o,
   output logic [AW-1:0]   bus_adr_o,
   output logic [DW-1:0]   bus_dat_o,
   input  logic [DW-1:0]   bus_dat_i,
   input  logic            bus_ack_i,
   input  logic            bus_err_i,
   output logic            timeout_o
);

   arb_state_t state;
   owner_t     last;
   logic       own_ins;
   logic       own_dat;
   logic       wd_expire;
   logic       ack_ok;
   logic       err_ok;
   logic       wd_clr;

   assign own_ins = (state == ARB_INS);
   assign own_dat = (state == ARB_DAT);

   // Grant FSM. A granted owner keeps the bus for as long as it holds cyc,
   // so multi-access sequences (pops, RTI) are never interleaved. Dropping
   // cyc always passes through IDLE before the other side can be granted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ARB_IDLE;
         last  <= OWN_DAT;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (ins_cyc_i && (!dat_cyc_i || (last == OWN_DAT)))
                  state <= ARB_INS;
               else if (dat_cyc_i)
                  state <= ARB_DAT;
            end
            ARB_INS: begin
               if (!ins_cyc_i) begin
                  state <= ARB_IDLE;
                  last  <= OWN_INS;
               end
            end
            ARB_DAT: begin
               if (!dat_cyc_i) begin
                  state <= ARB_IDLE;
                  last  <= OWN_DAT;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   // Bus mux. Strobe is qualified by cyc and suppressed during the
   // watchdog error cycle so the stalled access is abandoned on the bus.
   always_comb begin
      bus_cyc_o = 1'b0;
      bus_stb_o = 1'b0;
      bus_we_o  = 1'b0;
      bus_sel_o = '0;
      bus_adr_o = '0;
      bus_dat_o = '0;
      if (own_ins) begin
         bus_cyc_o = ins_cyc_i;
         bus_stb_o = ins_cyc_i & ins_stb_i & ~wd_expire;
         bus_we_o  = INS_WE;
         bus_sel_o = '1;
         bus_adr_o = ins_adr_i;
      end else if (own_dat) begin
         bus_cyc_o = dat_cyc_i;
         bus_stb_o = dat_cyc_i & dat_stb_i & ~wd_expire;
         bus_we_o  = dat_we_i;
         bus_sel_o = dat_sel_i;
         bus_adr_o = dat_adr_i;
         bus_dat_o = dat_dat_i;
      end
   end

   // Responses only count while a cycle is on the bus. A forced error
   // dominates: any late ack arriving in that cycle is discarded.
   assign ack_ok = bus_cyc_o & bus_ack_i & ~wd_expire;
   assign err_ok = (bus_cyc_o & bus_err_i) | wd_expire;

   assign ins_ack_o = own_ins & ack_ok;
   assign dat_ack_o = own_dat & ack_ok;
   assign ins_err_o = own_ins & err_ok;
   assign dat_err_o = own_dat & err_ok;

   // Read data fans out to both masters; held at zero while in reset so
   // every output is quiet without waiting for a clock edge.
   assign ins_dat_o = rst_i ? '0 : bus_dat_i;
   assign dat_dat_o = rst_i ? '0 : bus_dat_i;

   assign timeout_o = wd_expire;

   // Every grant change happens in a cycle where no owner drives cyc, so
   // clearing on "no cycle on the bus" also clears across state changes.
   assign wd_clr = ~bus_cyc_o;

   bexkat2_bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (wd_clr),
      .stb_i    (bus_stb_o),
      .done_i   ((bus_ack_i | bus_err_i) & bus_cyc_o),
      .expire_o (wd_expire)
   );

endmodule

// File: tb/tb_bexkat2_bus_arbiter.sv
// Directed bench for bexkat2_bus_arbiter with TIMEOUT=4.
// Inputs change 1ns after a rising edge, outputs are checked 2ns after it.
// Reports one summary line.
module tb_bexkat2_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk_i;
   logic            rst_i;
   logic            ins_cyc_i, ins_stb_i;
   logic [AW-1:0]   ins_adr_i;
   logic [DW-1:0]   ins_dat_o;
   logic            ins_ack_o, ins_err_o;
   logic            dat_cyc_i, dat_stb_i, dat_we_i;
   logic [DW/8-1:0] dat_sel_i;
   logic [AW-1:0]   dat_adr_i;
   logic [DW-1:0]   dat_dat_i, dat_dat_o;
   logic            dat_ack_o, dat_err_o;
   logic            bus_cyc_o, bus_stb_o, bus_we_o;
   logic [DW/8-1:0] bus_sel_o;
   logic [AW-1:0]   bus_adr_o;
   logic [DW-1:0]   bus_dat_o, bus_dat_i;
   logic            bus_ack_i, bus_err_i;
   logic            timeout_o;

   int checks   = 0;
   int failures = 0;

   bexkat2_bus_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ins_cyc_i (ins_cyc_i),
      .ins_stb_i (ins_stb_i),
      .ins_adr_i (ins_adr_i),
      .ins_dat_o (ins_dat_o),
      .ins_ack_o (ins_ack_o),
      .ins_err_o (ins_err_o),
      .dat_cyc_i (dat_cyc_i),
      .dat_stb_i (dat_stb_i),
      .dat_we_i  (dat_we_i),
      .dat_sel_i (dat_sel_i),
      .dat_adr_i (dat_adr_i),
      .dat_dat_i (dat_dat_i),
      .dat_dat_o (dat_dat_o),
      .dat_ack_o (dat_ack_o),
      .dat_err_o (dat_err_o),
      .bus_cyc_o (bus_cyc_o),
      .bus_stb_o (bus_stb_o),
      .bus_we_o  (bus_we_o),
      .bus_sel_o (bus_sel_o),
      .bus_adr_o (bus_adr_o),
      .bus_dat_o (bus_dat_o),
      .bus_dat_i (bus_dat_i),
      .bus_ack_i (bus_ack_i),
      .bus_err_i (bus_err_i),
      .timeout_o (timeout_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // ---------------- reset ----------------
      rst_i = 1'b1;
      ins_cyc_i = 0; ins_stb_i = 0; ins_adr_i = '0;
      dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0; dat_sel_i = '0;
      dat_adr_i = '0; dat_dat_i = '0;
      bus_dat_i = 32'h1111_1111; bus_ack_i = 0; bus_err_i = 0;
      #3;
      chk1("rst_bus_cyc", bus_cyc_o, 1'b0);
      chk1("rst_bus_stb", bus_stb_o, 1'b0);
      chk1("rst_timeout", timeout_o, 1'b0);
      chk1("rst_ins_ack", ins_ack_o, 1'b0);
      chk32("rst_ins_dat", ins_dat_o, 32'h0);
      #9 rst_i = 1'b0;

      // ---------------- tie from idle: fetch first, then data ----------------
      tick();
      ins_cyc_i = 1; ins_stb_i = 1; ins_adr_i = 32'h200;
      dat_cyc_i = 1; dat_stb_i = 1; dat_we_i = 1; dat_sel_i = 4'hF;
      dat_adr_i = 32'h300; dat_dat_i = 32'hDEAD_BEEF;
      #1;
      chk1("tie_idle_cyc", bus_cyc_o, 1'b0);
      tick();
      bus_ack_i = 1; bus_dat_i = 32'hA5A5_A5A5;
      #1;
      chk1("tie_ins_cyc", bus_cyc_o, 1'b1);
      chk32("tie_ins_adr", bus_adr_o, 32'h200);
      chk1("tie_ins_we", bus_we_o, 1'b0);
      chk32("tie_ins_sel", {28'h0, bus_sel_o}, 32'hF);
      chk32("tie_ins_wdat", bus_dat_o, 32'h0);
      chk1("tie_ins_ack", ins_ack_o, 1'b1);
      chk1("tie_dat_noack", dat_ack_o, 1'b0);
      chk32("tie_ins_rdat", ins_dat_o, 32'hA5A5_A5A5);
      tick();
      ins_cyc_i = 0; ins_stb_i = 0; bus_ack_i = 0;
      #1;
      chk1("tie_drop_cyc", bus_cyc_o, 1'b0);
      tick();
      #1;
      chk1("tie_gap_cyc", bus_cyc_o, 1'b0);
      tick();
      bus_ack_i = 1;
      #1;
      chk1("tie_dat_cyc", bus_cyc_o, 1'b1);
      chk1("tie_dat_we", bus_we_o, 1'b1);
      chk32("tie_dat_sel", {28'h0, bus_sel_o}, 32'hF);
      chk32("tie_dat_wdat", bus_dat_o, 32'hDEAD_BEEF);
      chk32("tie_dat_adr", bus_adr_o, 32'h300);
      chk1("tie_dat_ack", dat_ack_o, 1'b1);
      chk1("tie_ins_noack", ins_ack_o, 1'b0);
      tick();
      dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0; bus_ack_i = 0;
      tick();

      // ---------------- locked data sequence with fetch waiting ----------------
      dat_cyc_i = 1; dat_stb_i = 1; dat_adr_i = 32'h400; dat_sel_i = 4'hF;
      tick();
      ins_cyc_i = 1; ins_stb_i = 1; ins_adr_i = 32'h500; bus_ack_i = 1;
      #1;
      chk32("lock_adr0", bus_adr_o, 32'h400);
      chk1("lock_ack0", dat_ack_o, 1'b1);
      tick();
      dat_adr_i = 32'h404;
      #1;
      chk32("lock_adr1", bus_adr_o, 32'h404);
      tick();
      dat_adr_i = 32'h408;
      #1;
      chk32("lock_adr2", bus_adr_o, 32'h408);
      chk1("lock_ins_noack", ins_ack_o, 1'b0);
      tick();
      dat_cyc_i = 0; dat_stb_i = 0; bus_ack_i = 0;
      #1;
      chk1("lock_drop_cyc", bus_cyc_o, 1'b0);
      tick();
      #1;
      chk1("lock_gap_cyc", bus_cyc_o, 1'b0);
      tick();
      bus_ack_i = 1;
      #1;
      chk1("lock_ins_cyc", bus_cyc_o, 1'b1);
      chk32("lock_ins_adr", bus_adr_o, 32'h500);
      chk1("lock_ins_ack", ins_ack_o, 1'b1);
      tick();
      ins_cyc_i = 0; ins_stb_i = 0; bus_ack_i = 0;
      tick();

      // ---------------- spurious response while idle ----------------
      bus_ack_i = 1; bus_err_i = 1;
      dat_cyc_i = 1; dat_stb_i = 1; dat_we_i = 1; dat_sel_i = 4'h3;
      dat_adr_i = 32'h600; dat_dat_i = 32'hCAFE_F00D;
      #1;
      chk1("spur_ins_ack", ins_ack_o, 1'b0);
      chk1("spur_dat_ack", dat_ack_o, 1'b0);
      chk1("spur_dat_err", dat_err_o, 1'b0);
      chk1("spur_ins_err", ins_err_o, 1'b0);

      // ---------------- watchdog: four unanswered strobes ----------------
      tick();
      bus_ack_i = 0; bus_err_i = 0;
      #1;
      chk1("wd_c1_stb", bus_stb_o, 1'b1);
      chk32("wd_c1_sel", {28'h0, bus_sel_o}, 32'h3);
      chk1("wd_c1_to", timeout_o, 1'b0);
      tick();
      #1;
      chk1("wd_c2_to", timeout_o, 1'b0);
      tick();
      #1;
      chk1("wd_c3_to", timeout_o, 1'b0);
      tick();
      #1;
      chk1("wd_c4_to", timeout_o, 1'b0);
      chk1("wd_c4_err", dat_err_o, 1'b0);
      tick();
      bus_ack_i = 1;
      #1;
      chk1("wd_c5_to", timeout_o, 1'b1);
      chk1("wd_c5_err", dat_err_o, 1'b1);
      chk1("wd_c5_ins_err", ins_err_o, 1'b0);
      chk1("wd_c5_late_ack", dat_ack_o, 1'b0);
      chk1("wd_c5_stb", bus_stb_o, 1'b0);
      chk1("wd_c5_cyc", bus_cyc_o, 1'b1);
      tick();
      bus_ack_i = 0;
      #1;
      chk1("wd_c6_to", timeout_o, 1'b0);
      chk1("wd_c6_err", dat_err_o, 1'b0);
      chk1("wd_c6_stb", bus_stb_o, 1'b1);
      tick();
      dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0;
      tick();

      // ---------------- reset in the middle of a transaction ----------------
      dat_cyc_i = 1; dat_stb_i = 1; dat_we_i = 1; dat_adr_i = 32'h700;
      tick();
      bus_dat_i = 32'h55AA_55AA;
      #1;
      chk1("mid_cyc_pre", bus_cyc_o, 1'b1);
      chk32("mid_rdat_pre", dat_dat_o, 32'h55AA_55AA);
      #2 rst_i = 1'b1;
      #1;
      chk1("mid_rst_cyc", bus_cyc_o, 1'b0);
      chk1("mid_rst_stb", bus_stb_o, 1'b0);
      chk1("mid_rst_we", bus_we_o, 1'b0);
      chk32("mid_rst_adr", bus_adr_o, 32'h0);
      chk32("mid_rst_rdat", dat_dat_o, 32'h0);
      ins_cyc_i = 1; ins_stb_i = 1; ins_adr_i = 32'h800;
      tick();
      #2 rst_i = 1'b0;
      tick();
      #1;
      chk1("post_rst_cyc", bus_cyc_o, 1'b1);
      chk32("post_rst_adr", bus_adr_o, 32'h800);
      chk1("post_rst_we", bus_we_o, 1'b0);
      ins_cyc_i = 0; ins_stb_i = 0; dat_cyc_i = 0; dat_stb_i = 0; dat_we_i = 0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the bench can never hang.
   initial begin
      #50000;
      $display("FAIL global_timeout: simulation exceeded time bound");
      $fatal(1, "time bound expired");
   end

endmodule

// File: doc/bexkat2_bus_arbiter.md
Name: bexkat2_bus_arbiter

Overview:
Shares the single external memory bus between the bexkat2 instruction-fetch port (feeds MDR_IBUS) and the data port (feeds MDR_DBUS: load/store/push/pop/exception vector access). Wishbone-classic style; grants are locked per cycle-frame and alternated round-robin. A stall watchdog reports a bus error so control can enter S_EXC.

Parameters:
AW, 32, address width
DW, 32, data width (sel width DW/8)
TIMEOUT, 255, max stb cycles without ack/err before forced error; 0 disables watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  async active-high reset
ins_cyc_i  in  1  fetch cycle frame
ins_stb_i  in  1  fetch strobe (read only)
ins_adr_i  in  AW  fetch address
ins_dat_o  out  DW  fetch read data
ins_ack_o  out  1  fetch ack
ins_err_o  out  1  fetch error
dat_cyc_i  in  1  data cycle frame
dat_stb_i  in  1  data strobe
dat_we_i  in  1  data write enable
dat_sel_i  in  DW/8  data byte selects
dat_adr_i  in  AW  data address
dat_dat_i  in  DW  data write data
dat_dat_o  out  DW  data read data
dat_ack_o  out  1  data ack
dat_err_o  out  1  data error
bus_cyc_o  out  1  memory cycle frame
bus_stb_o  out  1  memory strobe
bus_we_o  out  1  memory write enable
bus_sel_o  out  DW/8  memory byte selects
bus_adr_o  out  AW  memory address
bus_dat_o  out  DW  memory write data
bus_dat_i  in  DW  memory read data
bus_ack_i  in  1  memory ack
bus_err_i  in  1  memory error
timeout_o  out  1  one-cycle pulse on watchdog error

Behaviour:
- One clock clk_i; reset rst_i is asynchronous, active-high. Reset: state ARB_IDLE, last=DAT (fetch wins first tie), watchdog count 0; all outputs 0 immediately, including mid-transaction.
- States: ARB_IDLE, ARB_INS, ARB_DAT. IDLE->INS if ins_cyc_i & ~dat_cyc_i, or both with last=DAT; IDLE->DAT symmetric. Grant registered: one cycle from IDLE request to bus_cyc_o.
- Granted state held while owner cyc high (locks multi-access sequences, e.g. RTI pops); owner cyc low -> IDLE on that edge, last:=owner. Minimum one IDLE cycle between owners, even if other requester is waiting.
- Granted: bus_cyc_o/stb/adr/we/sel/dat_o combinationally from owner; fetch forces we=0, sel=all ones, dat_o=0. IDLE: all bus outputs 0.
- bus_dat_i fans to both *_dat_o; ack/err routed only to owner, non-owner sees 0. bus_ack_i/bus_err_i ignored when bus_cyc_o=0.
- Watchdog: counts cycles with bus_stb_o=1 and no ack/err; cleared by ack, err, stb low, or state change. At count==TIMEOUT-1 with no ack/err: next cycle owner *_err_o=1 and timeout_o=1 for exactly one cycle, bus_stb_o forced 0 that cycle, count cleared; grant kept until owner drops cyc.
- Late bus_ack_i in the forced-error cycle is dropped (err wins). Simultaneous ack and err from bus: pass both; requester treats err as dominant.
- Counter width $clog2(TIMEOUT+1); saturates, never wraps.

Decomposition:
- Add arb_state_t enum bit[1:0] {ARB_IDLE, ARB_INS, ARB_DAT} to package bexkat1Def.
- Sub-module bexkat2_bus_watchdog (counter, clear, expire pulse), parameterised by TIMEOUT.

Test Plan:
- Reset, ins_cyc/stb=1 at 0x100, ack after 2 cycles -> bus_cyc_o rises one cycle later, bus_adr_o=0x100, bus_we_o=0, ins_ack_o once, dat_ack_o=0.
- Both cyc from IDLE, then repeat -> INS granted first, DAT second, DAT's write 0xDEADBEEF sel=0xF seen on bus_dat_o/bus_sel_o; one IDLE cycle between.
- DAT holds cyc over 3 strobes (pop sequence) while ins_cyc_i=1 -> no switch until dat_cyc_i falls; INS granted 2 cycles after.
- TIMEOUT=4, no ack -> dat_err_o and timeout_o high exactly one cycle after 4 stb cycles, bus_stb_o low that cycle.
- rst_i mid-transaction with bus_cyc_o=1 -> all outputs 0 without clock edge; after release, first tie goes to INS.
- Spurious bus_ack_i with bus_cyc_o=0 -> no *_ack_o.
